// File: rtl/clint_timer_arm_master.sv
// AXI4 initiator that arms mtimecmp[HART_ID] with mtime + delta.
// Optional CLINT_TIMER_ARM_PERIODIC_EN: re-arms mtimecmp on each timer_irq_i rising edge.
module clint_timer_arm_master #(
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter logic [63:0] CLINT_BASE     = 64'h0200_0000,
    parameter int unsigned HART_ID        = 0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        arm_valid_i,
    output logic                        arm_ready_o,
    input  logic [63:0]                 delta_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [63:0]                 cmp_o,
`ifdef CLINT_TIMER_ARM_PERIODIC_EN
    input  logic                        periodic_i,
    input  logic                        timer_irq_i,
`endif
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awcache,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awqos,
    output logic [3:0]                  m_axi_awregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_awuser,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_wuser,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_buser,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arcache,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arqos,
    output logic [3:0]                  m_axi_arregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_aruser,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_ruser,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("clint_timer_arm_master: AXI_DATA_WIDTH must be 64");
    end

    localparam logic [63:0] MTIME_ADDR    = CLINT_BASE + 64'hBFF8;
    localparam logic [63:0] MTIMECMP_ADDR = CLINT_BASE + 64'h4000 + 64'(8 * HART_ID);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE, S_DONE_ERR, S_WAIT
    } state_t;

    state_t      state_q;
    logic [63:0] delta_q;
    logic [63:0] cmp_q;
    logic [63:0] cmp_d;
    logic        arm_ready_q, busy_q, done_q, err_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        periodic_q;
    logic        aw_done, w_done;

    assign cmp_d   = m_axi_rdata[63:0] + delta_q;
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q || m_axi_wready;

`ifdef CLINT_TIMER_ARM_PERIODIC_EN
    logic irq_q;
    logic irq_rise;
    assign irq_rise = timer_irq_i && !irq_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) irq_q <= 1'b0;
        else          irq_q <= timer_irq_i;
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            delta_q     <= '0;
            cmp_q       <= '0;
            arm_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            periodic_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (arm_valid_i) begin
                    delta_q     <= delta_i;
                    err_q       <= 1'b0;
                    arm_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                    arvalid_q   <= 1'b1;
`ifdef CLINT_TIMER_ARM_PERIODIC_EN
                    periodic_q  <= periodic_i;
`else
                    periodic_q  <= 1'b0;
`endif
                    state_q     <= S_AR;
                end
                S_AR: if (m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_R;
                end
                S_R: if (m_axi_rvalid) begin
                    rready_q <= 1'b0;
                    if (m_axi_rresp != 2'b00) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE_ERR;
                    end else begin
                        cmp_q     <= cmp_d;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_AWW;
                    end
                end
                S_AWW: begin
                    // AW and W retire independently; move on once both have handshaken
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_B;
                    end
                end
                S_B: if (m_axi_bvalid) begin
                    bready_q <= 1'b0;
                    if (m_axi_bresp != 2'b00) err_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (periodic_q && !err_q) begin
                        state_q <= S_WAIT;
                    end else begin
                        periodic_q  <= 1'b0;
                        arm_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
`ifdef CLINT_TIMER_ARM_PERIODIC_EN
                S_WAIT: begin
                    if (!periodic_i) begin
                        periodic_q  <= 1'b0;
                        arm_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (irq_rise) begin
                        cmp_q     <= cmp_q + delta_q;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_AWW;
                    end
                end
`endif
                default: begin
                    periodic_q  <= 1'b0;
                    arm_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign arm_ready_o = arm_ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign cmp_o       = cmp_q;

    assign m_axi_arid     = '0;
    assign m_axi_araddr   = AXI_ADDR_WIDTH'(MTIME_ADDR);
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = 3'b011;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arprot   = '0;
    assign m_axi_arcache  = '0;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arqos    = '0;
    assign m_axi_arregion = '0;
    assign m_axi_aruser   = '0;
    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_rready   = rready_q;

    assign m_axi_awid     = '0;
    assign m_axi_awaddr   = AXI_ADDR_WIDTH'(MTIMECMP_ADDR);
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = 3'b011;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awprot   = '0;
    assign m_axi_awcache  = '0;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awqos    = '0;
    assign m_axi_awregion = '0;
    assign m_axi_awuser   = '0;
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_wdata    = AXI_DATA_WIDTH'(cmp_q);
    assign m_axi_wstrb    = '1;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_wuser    = '0;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_bready   = bready_q;

    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_buser, m_axi_rid, m_axi_rlast, m_axi_ruser};

endmodule
